// File: rtl/rv_alu_pkg.sv
// rtl/rv_alu_pkg.sv - shared ALU operation, opcode and funct3 constants for rv_alu_unit
package rv_alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SLL    = 4'd1;
  localparam logic [3:0] ALU_SLT    = 4'd2;
  localparam logic [3:0] ALU_SLTU   = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SRL    = 4'd5;
  localparam logic [3:0] ALU_OR     = 4'd6;
  localparam logic [3:0] ALU_AND    = 4'd7;
  localparam logic [3:0] ALU_SUB    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;
  localparam logic [3:0] ALU_XXX    = 4'd15;

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/rv_alu_decoder.sv
// rtl/rv_alu_decoder.sv - combinational map of {opcode, funct3, bit 30} to a 4-bit ALU operation
module rv_alu_decoder
  import rv_alu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct,
  input  logic       add_rshift_type,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_XXX;
    case (opcode)
      // funct3 values line up with the first eight ALU encodings
      OPC_ARI_RTYPE: begin
        alu_op = {1'b0, funct};
        if (add_rshift_type && funct == F3_ADD) alu_op = ALU_SUB;
        if (add_rshift_type && funct == F3_SRL) alu_op = ALU_SRA;
      end
      // bit 30 is part of the immediate for ADDI, so only SRAI honours it
      OPC_ARI_ITYPE: begin
        alu_op = {1'b0, funct};
        if (add_rshift_type && funct == F3_SRL) alu_op = ALU_SRA;
      end
      OPC_LUI: alu_op = ALU_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: alu_op = ALU_ADD;
      default: alu_op = ALU_XXX;
    endcase
  end

endmodule

// File: rtl/rv_alu_unit.sv
// rtl/rv_alu_unit.sv - RV32I execute ALU; RV_ALU_OUT_REG_EN adds a registered Out with sync reset
module rv_alu_unit
  import rv_alu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct,
  input  logic        add_rshift_type,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [3:0]  ALUop,
  output logic [31:0] Out
);

  logic [4:0]  shamt;
  logic [31:0] result;

  rv_alu_decoder u_decoder (
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .alu_op          (ALUop)
  );

  assign shamt = B[4:0];

  always_comb begin
    result = 32'h0;
    case (ALUop)
      ALU_ADD:    result = A + B;
      ALU_SUB:    result = A - B;
      ALU_SLL:    result = A << shamt;
      ALU_SRL:    result = A >> shamt;
      ALU_SRA:    result = $signed(A) >>> shamt;
      ALU_SLT:    result = {31'b0, $signed(A) < $signed(B)};
      ALU_SLTU:   result = {31'b0, A < B};
      ALU_XOR:    result = A ^ B;
      ALU_OR:     result = A | B;
      ALU_AND:    result = A & B;
      ALU_COPY_B: result = B;
      default:    result = 32'h0;
    endcase
  end

`ifdef RV_ALU_OUT_REG_EN
  always_ff @(posedge Clock) begin
    if (Reset) Out <= 32'h0;
    else       Out <= result;
  end
`else
  // Clock and Reset have no function in the combinational build
  wire unused_clk_rst = Clock ^ Reset;
  assign Out = result;
`endif

endmodule

// File: tb/tb_rv_alu_unit.sv
// tb/tb_rv_alu_unit.sv - self-checking bench for rv_alu_unit (either RV_ALU_OUT_REG_EN build)
module tb_rv_alu_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [6:0]  opcode = 7'b0;
  logic [2:0]  funct = 3'b0;
  logic        add_rshift_type = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [3:0]  ALUop;
  logic [31:0] Out;

  int n_cmp = 0;
  int n_fail = 0;
  bit check_en = 1'b0;
  logic [31:0] exp_reg = 32'h0;

  rv_alu_unit dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .A               (A),
    .B               (B),
    .ALUop           (ALUop),
    .Out             (Out)
  );

  always #5 Clock = ~Clock;

  function automatic int m_op(logic [6:0] opc, logic [2:0] f, logic t);
    int fi;
    fi = int'(f);
    if (opc == 7'b0110011) begin
      if (t && fi == 0) return 8;
      if (t && fi == 5) return 9;
      return fi;
    end
    if (opc == 7'b0010011) return (t && fi == 5) ? 9 : fi;
    if (opc == 7'b0110111) return 10;
    if (opc == 7'b0010111 || opc == 7'b1101111 || opc == 7'b1100111 ||
        opc == 7'b1100011 || opc == 7'b0000011 || opc == 7'b0100011) return 0;
    return 15;
  endfunction

  function automatic logic [31:0] m_out(int op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    int sa;
    int sb;
    longint unsigned wide;
    sh = b % 32;
    sa = a;
    sb = b;
    case (op)
      0:  begin wide = longint'(a) + longint'(b); return wide[31:0]; end
      8:  begin wide = longint'(a) + longint'(~b) + 64'd1; return wide[31:0]; end
      1:  return a * (32'd1 << sh);
      5:  return a / (32'd1 << sh);
      9:  return sa >>> sh;
      2:  return (sa < sb) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a ^ b;
      6:  return a | b;
      7:  return a & b;
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected registered output, tracked from the inputs seen at each edge
  always @(posedge Clock) begin
    if (Reset) exp_reg <= 32'h0;
    else       exp_reg <= m_out(m_op(opcode, funct, add_rshift_type), A, B);
  end

  always @(negedge Clock) begin
    if (check_en) begin
      check("model_aluop", {28'b0, ALUop}, 32'(m_op(opcode, funct, add_rshift_type)));
`ifdef RV_ALU_OUT_REG_EN
      check("model_out", Out, exp_reg);
`else
      check("model_out", Out, m_out(m_op(opcode, funct, add_rshift_type), A, B));
`endif
    end
  end

  // Inputs change just after a rising edge; results are read at the following falling edge
  task automatic apply(logic [6:0] opc, logic [2:0] f, logic t, logic [31:0] a, logic [31:0] b);
    opcode = opc;
    funct = f;
    add_rshift_type = t;
    A = a;
    B = b;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic vec(string name, logic [6:0] opc, logic [2:0] f, logic t,
                     logic [31:0] a, logic [31:0] b, logic [3:0] exp_op, logic [31:0] exp_out);
    apply(opc, f, t, a, b);
    check({name, "_op"}, {28'b0, ALUop}, {28'b0, exp_op});
    check({name, "_out"}, Out, exp_out);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    check("reset_out", Out, 32'h0);
    check("reset_op", {28'b0, ALUop}, 32'd15);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_en = 1'b1;

    vec("add",     7'b0110011, 3'b000, 1'b0, 32'd5, 32'd3, 4'd0, 32'h00000008);
    vec("sub",     7'b0110011, 3'b000, 1'b1, 32'd3, 32'd5, 4'd8, 32'hFFFFFFFE);
    vec("srl",     7'b0110011, 3'b101, 1'b0, 32'h80000000, 32'd4, 4'd5, 32'h08000000);
    vec("sra",     7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'd4, 4'd9, 32'hF8000000);
    vec("srai",    7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'd4, 4'd9, 32'hF8000000);
    vec("sll_b5",  7'b0110011, 3'b001, 1'b0, 32'd1, 32'h00000021, 4'd1, 32'h00000002);
    vec("slt",     7'b0110011, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd2, 32'd1);
    vec("sltu",    7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd3, 32'd0);
    vec("lui",     7'b0110111, 3'b000, 1'b0, 32'hDEADBEEF, 32'h12345000, 4'd10, 32'h12345000);
    vec("addi_b30",7'b0010011, 3'b000, 1'b1, 32'd7, 32'd1, 4'd0, 32'd8);
    vec("store",   7'b0100011, 3'b010, 1'b0, 32'h1000, 32'hFFFFFFFC, 4'd0, 32'h00000FFC);
    vec("illegal", 7'b0000000, 3'b000, 1'b0, 32'h1234, 32'h5678, 4'd15, 32'h0);
    vec("sra_31",  7'b0110011, 3'b101, 1'b1, 32'h80000000, 32'd31, 4'd9, 32'hFFFFFFFF);
    vec("sub_wrap",7'b0110011, 3'b000, 1'b1, 32'd0, 32'd1, 4'd8, 32'hFFFFFFFF);

    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 8; f++) begin
        for (int r = 0; r < 6; r++) begin
          apply((k == 0) ? 7'b0110011 : 7'b0010011, 3'(f), 1'($urandom_range(1)),
                $urandom, $urandom);
          @(posedge Clock);
          #1;
        end
      end
    end

    apply(7'b1100011, 3'b000, 1'b0, 32'h10, 32'h20);
    @(posedge Clock);
    #1;

`ifdef RV_ALU_OUT_REG_EN
    Reset = 1'b1;
    opcode = 7'b0110011; funct = 3'b000; add_rshift_type = 1'b0; A = 32'd9; B = 32'd9;
    @(posedge Clock);
    @(posedge Clock);
    @(negedge Clock);
    check("reg_reset", Out, 32'h0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    A = 32'd2;
    B = 32'd2;
    #1;
    check("reg_before_edge", Out, 32'h0);
    @(posedge Clock);
    #1;
    check("reg_after_edge", Out, 32'd4);
    Reset = 1'b1;
    A = 32'd100;
    @(posedge Clock);
    #1;
    check("reg_reset_again", Out, 32'h0);
    Reset = 1'b0;
`else
    Reset = 1'b1;
    apply(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd2);
    check("comb_ignores_reset", Out, 32'd4);
    Reset = 1'b0;
`endif

    @(posedge Clock);
    #1;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
